// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises bitstream words MSB-first into the
// ccff chain, then rotates the chain once and compares CRC-8 of load vs read-back.
module ccff_bitstream_loader #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              readback_err,
    output logic [LEN_W-1:0]  bit_count
);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [WB_W-1:0] WLAST = WB_W'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, VERIFY, FIN} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   wcnt;
    logic [7:0]        crc_load;
    logic [7:0]        crc_rb;
    logic [LEN_W-1:0]  bit_count_nxt;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ({8{c[7] ^ b}} & 8'h07);
    endfunction

    assign bit_count_nxt = bit_count + 1'b1;
    assign in_ready      = (state == LOAD);
    assign ccff_shift_en = (state == SHIFT) || (state == VERIFY);
    assign busy          = (state != IDLE);
    // During verify the tail is fed straight back so the rotation is non-destructive.
    assign ccff_head     = (state == VERIFY) ? ccff_tail :
                           (state == SHIFT)  ? shreg[WORD_W-1] : 1'b0;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state        <= IDLE;
            len          <= '0;
            shreg        <= '0;
            wcnt         <= '0;
            bit_count    <= '0;
            crc_load     <= '0;
            crc_rb       <= '0;
            done         <= 1'b0;
            readback_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        readback_err <= 1'b0;
                        bit_count    <= '0;
                        crc_load     <= '0;
                        crc_rb       <= '0;
                        len          <= chain_len;
                        state        <= (chain_len == '0) ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        wcnt  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg     <= shreg << 1;
                    wcnt      <= wcnt + 1'b1;
                    bit_count <= bit_count_nxt;
                    crc_load  <= crc8_step(crc_load, shreg[WORD_W-1]);
                    // A partial last word is abandoned once the chain is full.
                    if (bit_count_nxt == len) begin
                        bit_count <= '0;
                        state     <= VERIFY;
                    end else if (wcnt == WLAST) begin
                        state <= LOAD;
                    end
                end
                VERIFY: begin
                    bit_count <= bit_count_nxt;
                    crc_rb    <= crc8_step(crc_rb, ccff_tail);
                    if (bit_count_nxt == len) state <= FIN;
                end
                FIN: begin
                    done         <= 1'b1;
                    readback_err <= (crc_load != crc_rb);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomised bench for ccff_bitstream_loader: a bit-list model of the chain and
// CRC predicts each run; a monitor pops expectations on every done pulse.
module tb_ccff_bitstream_loader;
    localparam int WORD_W = 8;
    localparam int LEN_W  = 16;
    localparam int MAXL   = 64;

    logic              prog_clk = 1'b0;
    logic              pReset_n = 1'b0;
    logic              start    = 1'b0;
    logic [LEN_W-1:0]  chain_len = '0;
    logic [WORD_W-1:0] in_data  = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, ccff_head, ccff_tail, ccff_shift_en;
    logic              busy, done, readback_err;
    logic [LEN_W-1:0]  bit_count;

    int checks = 0;
    int errors = 0;

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .chain_len(chain_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en), .busy(busy), .done(done),
        .readback_err(readback_err), .bit_count(bit_count)
    );

    // ---------------- chain model ----------------
    logic [MAXL-1:0] chain = '0;
    logic [MAXL-1:0] mdl_nxt;
    int cur_len = 0;
    int sh_cnt  = 0;
    int cidx    = -1;
    logic corrupt_req = 1'b0;
    int   corrupt_idx_req = 0;

    assign ccff_tail = (cur_len == 0) ? 1'b0 : chain[cur_len-1];

    always @(posedge prog_clk) begin
        if (pReset_n && start && !busy) begin
            cur_len <= int'(chain_len);
            sh_cnt  <= 0;
            cidx    <= corrupt_req ? corrupt_idx_req : -1;
            chain   <= {$urandom, $urandom};
        end else if (ccff_shift_en) begin
            mdl_nxt = {chain[MAXL-2:0], ccff_head};
            // Disturb one cell right after the last load shift, before verify starts.
            if (cidx >= 0 && sh_cnt == cur_len - 1) mdl_nxt[cidx] = ~mdl_nxt[cidx];
            chain  <= mdl_nxt;
            sh_cnt <= sh_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic            err;
        int              len;
        logic [MAXL-1:0] chain;
    } exp_t;
    exp_t sb[$];

    logic [WORD_W-1:0] fixed_words[$];
    logic stall_chk = 1'b0;
    logic rst_chk   = 1'b0;
    logic end_chk   = 1'b0;
    int   zc_phase  = 0;

    function automatic logic [7:0] crc8(input logic [MAXL-1:0] v, input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++) c = {c[6:0], 1'b0} ^ ({8{c[7] ^ v[i]}} & 8'h07);
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t            m_e;
    logic [MAXL-1:0] m_mask;
    logic            last_err = 1'b0;
    logic            end_done = 1'b0;

    always @(negedge prog_clk) begin
        if (!pReset_n) last_err = 1'b0;
        if (rst_chk)
            chk("reset_outputs", {57'd0, in_ready, ccff_shift_en, busy, done, readback_err,
                ccff_head, |bit_count}, 64'd0);
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                m_e = sb.pop_front();
                chk("readback_err", {63'd0, readback_err}, {63'd0, m_e.err});
                chk("shift_count", 64'(sh_cnt), 64'(2 * m_e.len));
                m_mask = '0;
                for (int i = 0; i < m_e.len; i++) m_mask[i] = 1'b1;
                chk("chain_contents", chain & m_mask, m_e.chain & m_mask);
                last_err = m_e.err;
            end
        end
        if (pReset_n && !busy) chk("err_hold", {63'd0, readback_err}, {63'd0, last_err});
        if (stall_chk) chk("stall_ready_noshift", {62'd0, in_ready, ccff_shift_en}, 64'd2);
        if (zc_phase == 1)
            chk("zero_len_fin", {61'd0, done, in_ready, ccff_shift_en}, 64'd0);
        if (zc_phase == 2) chk("zero_len_done_at_2", {63'd0, done}, 64'd1);
        if (end_chk && !end_done) begin
            chk("scoreboard_drained", 64'(sb.size()), 64'd0);
            end_done = 1'b1;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge prog_clk);
        #2;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready) begin
            step();
            n++;
            if (n > 1000) begin
                $display("FAIL wait_ready: in_ready stuck low after %0d cycles", n);
                $fatal(1);
            end
        end
    endtask

    task automatic run(input int len, input bit corrupt, input int ci, input int stall,
                       input bit restart, input bit abort);
        logic [WORD_W-1:0] words[$];
        logic [WORD_W-1:0] w;
        logic [MAXL-1:0]   lb, lc;
        exp_t e;
        int nw, n;
        nw = (len + WORD_W - 1) / WORD_W;
        for (int k = 0; k < nw; k++)
            words.push_back((fixed_words.size() > 0) ? fixed_words.pop_front()
                                                     : WORD_W'($urandom));
        fixed_words.delete();
        lb = '0;
        for (int i = 0; i < len; i++) begin
            w = words[i / WORD_W];
            lb[i] = w[WORD_W - 1 - (i % WORD_W)];
        end
        lc = lb;
        if (corrupt) lc[len - 1 - ci] = ~lc[len - 1 - ci];
        e.err = (crc8(lb, len) != crc8(lc, len));
        e.len = len;
        e.chain = '0;
        for (int i = 0; i < len; i++) e.chain[len - 1 - i] = lc[i];
        if (!abort) sb.push_back(e);

        corrupt_req = corrupt;
        corrupt_idx_req = ci;
        chain_len = LEN_W'(len);
        start = 1'b1;
        step();
        start = 1'b0;
        if (len == 0) begin
            zc_phase = 1;
            step();
            zc_phase = 2;
            step();
            zc_phase = 0;
        end
        for (int k = 0; k < nw; k++) begin
            if (stall > 0 && k == nw - 1) begin
                in_valid = 1'b0;
                wait_ready();
                stall_chk = 1'b1;
                repeat (stall) step();
                stall_chk = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = words[k];
            wait_ready();
            step();
            if (abort && k == 0) begin
                repeat (3) step();
                pReset_n = 1'b0;
                rst_chk  = 1'b1;
                step();
                rst_chk  = 1'b0;
                pReset_n = 1'b1;
                in_valid = 1'b0;
                step();
                return;
            end
            if (restart && k == 0) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (busy) begin
            step();
            n++;
            if (n > 1000) begin
                $display("FAIL run_timeout: busy stuck high, len=%0d", len);
                $fatal(1);
            end
        end
        step();
    endtask

    task automatic load_std();
        fixed_words.push_back(8'hA5);
        fixed_words.push_back(8'h3C);
    endtask

    initial begin
        rst_chk = 1'b1;
        repeat (3) step();
        rst_chk = 1'b0;
        pReset_n = 1'b1;
        step();

        load_std(); run(12, 1'b0, 0, 0, 1'b0, 1'b0);
        load_std(); run(12, 1'b1, 5, 0, 1'b0, 1'b0);
        repeat (6) step();
        load_std(); run(12, 1'b0, 0, 5, 1'b0, 1'b0);
        run(0, 1'b0, 0, 0, 1'b0, 1'b0);
        load_std(); run(12, 1'b1, 5, 0, 1'b0, 1'b0);
        run(0, 1'b0, 0, 0, 1'b0, 1'b0);
        load_std(); run(12, 1'b0, 0, 0, 1'b1, 1'b0);
        load_std(); run(12, 1'b0, 0, 0, 1'b0, 1'b1);
        load_std(); run(12, 1'b0, 0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            int len, ci, st;
            bit cor;
            len = $urandom_range(MAXL, 1);
            cor = ($urandom_range(2, 0) == 0);
            ci  = $urandom_range(len - 1, 0);
            st  = $urandom_range(3, 0);
            run(len, cor, ci, st, ($urandom_range(4, 0) == 0), 1'b0);
            repeat ($urandom_range(3, 0)) step();
        end
        run(MAXL, 1'b1, 0, 0, 1'b0, 1'b0);
        run(1, 1'b1, 0, 2, 1'b0, 1'b0);

        end_chk = 1'b1;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Programming-side driver for the configuration-chain flip-flops whose outputs become the mem/mem_inv select bits of the routing and LUT mux primitives.
- Accepts bitstream words over a valid/ready stream and serialises them, MSB first, into the configuration chain head.
- After loading, it rotates the chain once (tail fed back to head), which leaves the programmed contents intact. During the rotation it reads the tail and compares a CRC-8 of the read-back bits against a CRC-8 of the loaded bits.

Parameters:
- WORD_W, 8, width of each incoming bitstream word.
- LEN_W, 16, width of the chain-length and bit counters; max chain length is 2^LEN_W-1.

Ports:
- prog_clk  in  1  programming clock; all state changes on its rising edge.
- pReset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a program-and-verify run; sampled only in IDLE.
- chain_len  in  LEN_W  total configuration bits in the chain; captured when start is accepted.
- in_data  in  WORD_W  bitstream word, MSB shifted first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word this cycle.
- ccff_head  out  1  serial data into the chain head.
- ccff_tail  in  1  serial data out of the chain tail; this is a flip-flop output.
- ccff_shift_en  out  1  chain shift enable; the chain shifts one position on each prog_clk where this is high.
- busy  out  1  run in progress (any state other than IDLE).
- done  out  1  one-cycle pulse at the end of a run.
- readback_err  out  1  CRC mismatch on the last run; held until the next accepted start.
- bit_count  out  LEN_W  bits shifted in the current phase.

Behaviour:
- Reset: state IDLE; in_ready, ccff_shift_en, busy, done, readback_err = 0; bit_count = 0; both CRCs = 0; ccff_head = 0. Chain contents are not touched. Reset mid-run aborts immediately and no done pulse is produced.
- FSM states: IDLE, LOAD, SHIFT, VERIFY, FIN.
- IDLE:
  - start=1 with chain_len=0 -> FIN; readback_err cleared.
  - start=1 with chain_len>0 -> LOAD; len captured, bit_count=0, CRCs=0, readback_err cleared.
  - start is ignored in every state other than IDLE.
- LOAD:
  - in_ready=1 combinationally, and only in this state.
  - On in_valid&in_ready, the word is registered into the shift register and the state moves to SHIFT.
  - in_valid low simply stalls; there is no timeout.
- SHIFT:
  - ccff_shift_en=1 and ccff_head=shreg MSB each cycle; shreg shifts left; bit_count increments.
  - crc_load is updated with the head bit.
  - Exit after WORD_W bits, or earlier when bit_count reaches len (the rest of the word is discarded).
  - If bit_count==len -> VERIFY with bit_count reset to 0; otherwise -> LOAD.
- VERIFY:
  - ccff_shift_en=1 and ccff_head=ccff_tail (combinational mux of the registered tail); crc_rb is updated with ccff_tail; runs for exactly len cycles.
  - The tail emits bits in original load order, so the CRCs match when the chain is intact.
- FIN: done=1 for one cycle; readback_err = (crc_load != crc_rb); next state IDLE.
- CRC: CRC-8 with polynomial x^8+x^2+x+1 (0x07), init 0x00, serial update crc = {crc[6:0],0} ^ ({8{crc[7]^bit}} & 8'h07), no final XOR.
- ccff_shift_en is 0 in IDLE, LOAD and FIN, so the chain holds its value across input stalls.
- busy=1 in LOAD, SHIFT, VERIFY and FIN.
- Counter and state widths come from LEN_W and WORD_W only; no wrap is possible because len is at most 2^LEN_W-1.

Test Plan:
- WORD_W=8, chain_len=12, words 0xA5 then 0x3C, in_valid always high, bench models the chain as a 12-bit shift register -> chain holds 101001010011 (first bit at tail); shift_en high for exactly 12 cycles in load and 12 in verify; done pulses once; readback_err=0; chain after verify is unchanged.
- Same run, but the bench flips chain bit 5 after the last SHIFT cycle and before VERIFY -> done pulses, readback_err=1 and stays 1 until the next start.
- Back-pressure: in_valid held low for 5 cycles while in LOAD -> in_ready=1 and ccff_shift_en=0 throughout the gap; final chain contents and readback_err=0 are identical to the no-stall run.
- start with chain_len=0 -> done pulses 2 cycles after start; in_ready, ccff_shift_en and readback_err never go high.
- start pulsed again during SHIFT -> ignored; exactly one done pulse and 12 load shifts.
- pReset_n driven low mid-SHIFT after 3 bits -> all outputs drop to 0 immediately with no done pulse; a subsequent full run completes with readback_err=0.
